kd_tree_traverse_pipe: RTL
==========================

// Module: kd_tree_traverse_pipe
// PURPOSE
//  Parametrised successor to the fixed-size internal-node tree: stores the 2^DEPTH-1 internal nodes of a KD-tree
//  (split dim + signed median) and routes K-dim patches through a DEPTH-stage pipeline to a leaf index.
//  Nodes stream in from the aggregator; queries use valid/ready with full backpressure, one patch/cycle.
// PARAMETERS
//  DATA_W   11  signed width of one patch element and of a median
//  K        5   dimensions per patch
//  DEPTH    6   tree levels = pipeline stages; leaves = 2^DEPTH
//  DIM_W    3   width of split-dim field (>= clog2(K))
// PORTS
//  wclk        in   1                 clock, all logic rising-edge
//  wrst_n      in   1                 reset, synchronous, active-low
//  load_start  in   1                 pulse: restart node load, flush pipeline
//  node_valid  in   1                 node word valid
//  node_ready  out  1                 node word accepted when valid&ready
//  node_data   in   DATA_W+DIM_W      {median[DATA_W-1:0], dim[DIM_W-1:0]}
//  loaded      out  1                 all 2^DEPTH-1 nodes written
//  in_valid    in   1                 patch valid
//  in_ready    out  1                 patch accepted when valid&ready
//  patch_in    in   K*DATA_W          dim d at [(K-1-d)*DATA_W +: DATA_W] (dim 0 in MSBs), signed
//  out_valid   out  1                 leaf result valid
//  out_ready   in   1                 consumer accepts result
//  out_leaf    out  DEPTH             leaf index 0..2^DEPTH-1
//  dim_err     out  1                 sticky: a node with dim >= K was used
// BEHAVIOUR
//  Reset: node regs, load count, loaded, all stage valids, out_valid, out_leaf, dim_err = 0.
//  Storage: heap-ordered regs; node i children 2i+1 (left), 2i+2 (right); write order = heap index 0,1,2...
//  Load: node_ready = !loaded. Each handshake writes node[cnt], cnt++; on cnt == 2^DEPTH-2 handshake,
//   loaded<=1 next cycle. Extra node words while loaded: not accepted (node_ready=0).
//  load_start: next cycle cnt=0, loaded=0, all stage valids and out_valid cleared (in-flight queries dropped,
//   no output); node_valid/in_valid in the same cycle are ignored (load_start wins). Node contents not cleared.
//  Query: in_ready = loaded & (!out_valid | out_ready). Stall = out_valid & !out_ready freezes every stage.
//  Stage s (0..DEPTH-1) holds {valid, patch, node idx n}; stage 0 n=0. Decision: x = patch[dim(n)];
//   x < median (signed) -> left, else right (tie goes right). n' = 2n+1 or 2n+2.
//  After stage DEPTH-1: out_leaf = n' - (2^DEPTH-1); i.e. leaf bits are the left/right decisions, MSB = root.
//  Latency: patch accepted at edge t -> out_valid=1 after edge t+DEPTH (no stall). Throughput 1/cycle.
//  Output held stable while out_valid & !out_ready; out_valid drops after handshake if no new result.
//  dim >= K: treated as left branch, dim_err<=1 (cleared only by reset).
//  Queries are never accepted while !loaded; reload mid-stream requires load_start.
// TESTING  (DATA_W=11, K=2, DEPTH=2 unless stated; nodes: n0{dim0,0} n1{dim1,10} n2{dim1,-10})
//  Load 3 nodes with random node_valid gaps -> loaded=1 one cycle after 3rd handshake; node_ready=0 after.
//  Patches (5,3),(-4,20),(-4,9),(0,-10) back-to-back -> leaves 3,1,0,3, each DEPTH cycles after accept, 1/cycle.
//  Random out_ready low during stream -> no lost/duplicated/reordered results; out_leaf stable while stalled.
//  load_start with 2 queries in flight -> no out_valid for them, loaded=0, in_ready=0 until reload done.
//  Node n1 dim=3 (>=K) -> patch (-4,20) gives leaf 0, dim_err=1 and stays 1.
//  DEPTH=6,K=5 with exported 63-node tree: patch (251,-26,-1,-88,79) -> 59; (279,-18,-55,-22,18) -> 60.

Source files
------------

// File: rtl/kd_tree_traverse_pipe.sv
// KD-tree traversal: routes K-dim signed patches through DEPTH heap-ordered split nodes to a leaf index.
// Latency: patch accepted at edge t gives out_valid after edge t+DEPTH; one patch per cycle.
// Backpressure: out_valid & !out_ready freezes every stage and drops in_ready; load_start flushes.
//
// Ports:
//   wclk, wrst_n             clock, synchronous active-low reset
//   load_start               restart node load and flush all in-flight queries
//   node_valid/ready/data    node stream {median, dim}, written in heap order 0,1,2...
//   loaded                   all 2^DEPTH-1 nodes written; queries accepted only while set
//   in_valid/ready, patch_in query patch, dim 0 in the MSBs, signed elements
//   out_valid/ready,out_leaf leaf index, MSB = root decision
//   dim_err                  sticky: a valid query visited a node whose dim >= K
module kd_tree_traverse_pipe #(
    parameter int DATA_W = 11,
    parameter int K      = 5,
    parameter int DEPTH  = 6,
    parameter int DIM_W  = 3
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    load_start,
    input  logic                    node_valid,
    output logic                    node_ready,
    input  logic [DATA_W+DIM_W-1:0] node_data,
    output logic                    loaded,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [K*DATA_W-1:0]     patch_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DEPTH-1:0]        out_leaf,
    output logic                    dim_err
);

    localparam int NNODES = (1 << DEPTH) - 1;

    // node storage, heap ordered
    logic signed [DATA_W-1:0] nd_med [NNODES];
    logic [DIM_W-1:0]         nd_dim [NNODES];
    logic [DEPTH-1:0]         ld_cnt;

    // pipeline stage registers; stg_path holds the decisions taken so far (s bits at stage s)
    logic [DEPTH-1:0]     stg_vld;
    logic [K*DATA_W-1:0]  stg_patch [DEPTH];
    logic [DEPTH-1:0]     stg_path  [DEPTH];

    // per-stage decision signals
    logic [DEPTH-1:0][DEPTH-1:0]  stg_idx;
    logic [DEPTH-1:0][DATA_W-1:0] sel_x;
    logic [DEPTH-1:0]             go_right;
    logic [DEPTH-1:0]             bad_dim;

    logic stall;
    logic advance;
    logic node_acc;
    logic in_acc;

    assign stall      = out_valid & ~out_ready;
    assign advance    = ~stall;
    assign in_ready   = loaded & ~stall;
    assign node_ready = ~loaded;
    // load_start wins over any handshake in the same cycle
    assign node_acc   = node_valid & node_ready & ~load_start;
    assign in_acc     = in_valid & in_ready & ~load_start;

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            // heap index of the node at level s reached by path p is 2^s - 1 + p
            stg_idx[s] = DEPTH'((1 << s) - 1) + stg_path[s];
            sel_x[s]   = '0;
            for (int k = 0; k < K; k++) begin
                if (nd_dim[stg_idx[s]] == DIM_W'(k)) begin
                    sel_x[s] = stg_patch[s][(K-1-k)*DATA_W +: DATA_W];
                end
            end
            bad_dim[s]  = (int'(nd_dim[stg_idx[s]]) >= K);
            // equal to median goes right; an out-of-range dim is forced left
            go_right[s] = ~bad_dim[s] & ~($signed(sel_x[s]) < nd_med[stg_idx[s]]);
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            ld_cnt    <= '0;
            loaded    <= 1'b0;
            stg_vld   <= '0;
            out_valid <= 1'b0;
            out_leaf  <= '0;
            dim_err   <= 1'b0;
            for (int i = 0; i < NNODES; i++) begin
                nd_med[i] <= '0;
                nd_dim[i] <= '0;
            end
            for (int s = 0; s < DEPTH; s++) begin
                stg_patch[s] <= '0;
                stg_path[s]  <= '0;
            end
        end else begin
            if ((stg_vld & bad_dim) != '0) begin
                dim_err <= 1'b1;
            end
            if (load_start) begin
                // node contents are kept; they are simply overwritten by the next load
                ld_cnt    <= '0;
                loaded    <= 1'b0;
                stg_vld   <= '0;
                out_valid <= 1'b0;
            end else begin
                if (node_acc) begin
                    nd_med[ld_cnt] <= node_data[DATA_W+DIM_W-1:DIM_W];
                    nd_dim[ld_cnt] <= node_data[DIM_W-1:0];
                    ld_cnt         <= ld_cnt + DEPTH'(1);
                    if (ld_cnt == DEPTH'(NNODES - 1)) begin
                        loaded <= 1'b1;
                    end
                end
                if (advance) begin
                    stg_vld[0]   <= in_acc;
                    stg_patch[0] <= patch_in;
                    stg_path[0]  <= '0;
                    for (int s = 1; s < DEPTH; s++) begin
                        stg_vld[s]   <= stg_vld[s-1];
                        stg_patch[s] <= stg_patch[s-1];
                        stg_path[s]  <= {stg_path[s-1][DEPTH-2:0], go_right[s-1]};
                    end
                    out_valid <= stg_vld[DEPTH-1];
                    if (stg_vld[DEPTH-1]) begin
                        out_leaf <= {stg_path[DEPTH-1][DEPTH-2:0], go_right[DEPTH-1]};
                    end
                end
            end
        end
    end

endmodule
